// File: rtl/ucode_loader_if.sv
// rtl/ucode_loader_if.sv - host byte-stream handshake into the microcode loader
interface ucode_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ucode_loader.sv
// rtl/ucode_loader.sv - framed byte-stream writer for the sequencer program RAM
module ucode_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  ucode_loader_if.slave     host,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [31:0]       prog_d,
  output logic              core_reset,
  input  logic              core_done,
  output logic              run_done,
  output logic              error
);

  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, RUN, ERR} state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t          state, state_nxt;
  logic [7:0]      len_lo;
  logic [15:0]     last_idx;
  logic [ADDR_W:0] word_idx;
  logic [1:0]      byte_cnt;
  logic [23:0]     shreg;
  logic [7:0]      csum;

  logic        accept;
  logic [15:0] n_len;
  logic        len_bad;
  logic        word_last;
  logic [31:0] word_full;

  assign accept    = host.in_valid && host.in_ready;
  assign n_len     = {host.in_data, len_lo};
  assign len_bad   = (n_len == 16'd0) || ({1'b0, n_len} > DEPTH_L);
  assign word_last = (16'(word_idx) == last_idx);
  // Bytes arrive LSB first, so the final byte lands on top of the three held ones.
  assign word_full = {host.in_data, shreg};

  always_ff @(posedge clk) begin
    if (reset) state <= LEN0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LEN0: if (accept) state_nxt = LEN1;
      LEN1: if (accept) state_nxt = len_bad ? ERR : DATA;
      DATA: if (accept && byte_cnt == 2'd3 && word_last)
              state_nxt = (host.in_data[7:2] != 6'd0) ? ERR : CSUM;
      CSUM: if (accept) state_nxt = (host.in_data == csum) ? RUN : ERR;
      RUN:  if (core_done) state_nxt = LEN0;
      ERR:  state_nxt = ERR;
      default: state_nxt = LEN0;
    endcase
  end

  always_comb begin
    host.in_ready = 1'b1;
    core_reset    = 1'b1;
    error         = 1'b0;
    case (state)
      RUN: begin
        host.in_ready = 1'b0;
        core_reset    = 1'b0;
      end
      ERR: begin
        host.in_ready = 1'b0;
        error         = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prog_we   <= 1'b0;
      prog_addr <= '0;
      prog_d    <= '0;
      run_done  <= 1'b0;
      len_lo    <= '0;
      last_idx  <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      csum      <= '0;
    end else begin
      prog_we  <= 1'b0;
      run_done <= (state == RUN) && core_done;
      case (state)
        LEN0: if (accept) len_lo <= host.in_data;
        LEN1: if (accept) begin
          last_idx <= n_len - 16'd1;
          word_idx <= '0;
          byte_cnt <= '0;
          csum     <= '0;
        end
        DATA: if (accept) begin
          csum     <= csum ^ host.in_data;
          shreg    <= {host.in_data, shreg[23:8]};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            prog_we   <= 1'b1;
            prog_addr <= word_idx[ADDR_W-1:0];
            prog_d    <= word_full;
            word_idx  <= word_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ucode_loader.sv
// tb/tb_ucode_loader.sv - directed scoreboard bench for ucode_loader
module tb_ucode_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [9:0]  prog_addr;
  logic [31:0] prog_d;
  logic        core_reset;
  logic        core_done;
  logic        run_done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [41:0] exp_q[$];
  logic [41:0] obs_q[$];
  logic [31:0] frame_q[$];

  ucode_loader_if bus ();

  ucode_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
    .clk        (clk),
    .reset      (reset),
    .host       (bus.slave),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_d     (prog_d),
    .core_reset (core_reset),
    .core_done  (core_done),
    .run_done   (run_done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (prog_we === 1'b1) obs_q.push_back({prog_addr, prog_d});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k == 20) begin
      chk("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input bit gaps, input bit send_csum,
                            input logic [7:0] flip, input logic [15:0] n);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < frame_q.size(); i++) begin
      for (int j = 0; j < 4; j++) begin
        b = frame_q[i][8*j +: 8];
        x ^= b;
        if (gaps) idle($urandom_range(0, 2));
        send_byte(b);
      end
      exp_q.push_back({10'(i), frame_q[i]});
    end
    if (send_csum) send_byte(x ^ flip);
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk(tag, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    core_done    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_prog_we", prog_we, 0);
    chk("rst_prog_addr", prog_addr, 0);
    chk("rst_prog_d", prog_d, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_run_done", run_done, 0);
    chk("rst_error", error, 0);

    // minimal frame, byte-level timing
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    chk("min_we", prog_we, 1);
    chk("min_addr", prog_addr, 0);
    chk("min_d", prog_d, 0);
    exp_q.push_back(42'd0);
    chk("min_core_reset_load", core_reset, 1);
    send_byte(8'h00);
    chk("min_core_reset_fall", core_reset, 0);
    chk("min_we_one_cycle", prog_we, 0);
    idle(3);
    chk("min_run_core_reset", core_reset, 0);
    chk("min_run_in_ready", bus.in_ready, 0);
    pulse_done();
    chk("min_run_done", run_done, 1);
    chk("min_core_reset_back", core_reset, 1);
    chk("min_in_ready_back", bus.in_ready, 1);
    idle(1);
    chk("min_run_done_pulse", run_done, 0);
    check_writes("min_wr");

    // three words with random valid gaps
    frame_q = '{32'h0400_1234, 32'h0800_0055, 32'h0000_0000};
    send_frame(1'b1, 1'b1, 8'h00, 16'd3);
    chk("three_core_reset", core_reset, 0);
    chk("three_error", error, 0);
    pulse_done();
    chk("three_run_done", run_done, 1);
    check_writes("three_wr");

    // corrupted checksum
    idle(1);
    frame_q = '{32'h0123_4567};
    send_frame(1'b0, 1'b1, 8'h01, 16'd1);
    chk("badcs_error", error, 1);
    chk("badcs_in_ready", bus.in_ready, 0);
    chk("badcs_core_reset", core_reset, 1);
    pulse_done();
    chk("badcs_done_ignored", run_done, 0);
    chk("badcs_error_sticky", error, 1);
    do_reset();
    chk("badcs_error_cleared", error, 0);
    chk("badcs_in_ready_back", bus.in_ready, 1);
    check_writes("badcs_wr");

    // illegal lengths
    send_byte(8'h00); send_byte(8'h00);
    chk("len0_error", error, 1);
    chk("len0_in_ready", bus.in_ready, 0);
    do_reset();
    send_byte(8'h01); send_byte(8'h04);
    chk("len1025_error", error, 1);
    chk("len1025_in_ready", bus.in_ready, 0);
    do_reset();
    check_writes("len_err_wr");

    // full-depth frame
    frame_q.delete();
    for (int i = 0; i < 1024; i++)
      frame_q.push_back((i == 1023) ? 32'h0 : (32'h00A5_0000 | 32'(i * 7)));
    send_frame(1'b0, 1'b1, 8'h00, 16'd1024);
    chk("depth_core_reset", core_reset, 0);
    chk("depth_error", error, 0);
    pulse_done();
    chk("depth_run_done", run_done, 1);
    check_writes("depth_wr");

    // last word without halt opcode
    frame_q = '{32'h0400_0000};
    send_frame(1'b0, 1'b0, 8'h00, 16'd1);
    chk("nohalt_error", error, 1);
    chk("nohalt_in_ready", bus.in_ready, 0);
    idle(2);
    chk("nohalt_in_ready_hold", bus.in_ready, 0);
    chk("nohalt_core_reset", core_reset, 1);
    do_reset();
    check_writes("nohalt_wr");

    // reset during word 1 discards the partial word
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    exp_q.push_back({10'd0, 32'h0000_00AA});
    send_byte(8'h11); send_byte(8'h22);
    do_reset();
    idle(2);
    check_writes("midframe_wr");
    frame_q = '{32'h0000_0077};
    send_frame(1'b0, 1'b1, 8'h00, 16'd1);
    chk("reload_core_reset", core_reset, 0);
    pulse_done();
    chk("reload_run_done", run_done, 1);
    check_writes("reload_wr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ucode_loader.md
# ucode_loader

Host-side writer for the microcode program memory that the core's sequencer reads. Accepts a framed byte stream (length, little-endian 32-bit command words, XOR checksum) over a valid/ready handshake and writes each word into the program RAM. Holds the sequencer in reset during loading, releases it once the frame is verified, and reports completion when the sequencer pulses its done line.

## Interface
Parameters:
- ADDR_W, 10, program RAM address width
- DEPTH, 1024, maximum command words per frame (≤ 2^ADDR_W)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  host byte valid
- in_data  in  8  host byte
- in_ready  out  1  loader accepts byte; transfer when in_valid && in_ready
- prog_we  out  1  program RAM write strobe
- prog_addr  out  ADDR_W  program RAM write address
- prog_d  out  32  program RAM write data
- core_reset  out  1  held-in-reset control to sequencer, active-high
- core_done  in  1  sequencer done pulse
- run_done  out  1  one-cycle pulse: program finished
- error  out  1  sticky frame error

## Operation
- Frame: LEN_LO, LEN_HI (N, 16-bit), then 4·N payload bytes (word k = bytes b0..b3, b0 = bits[7:0]), then CSUM = XOR of all 4·N payload bytes. Length bytes excluded from CSUM.
- States: LEN0, LEN1, DATA, CSUM, RUN, ERR.
- LEN0: accept LEN_LO → LEN1.
- LEN1: accept LEN_HI; N = 0 or N > DEPTH → ERR; else word index 0, byte count 0, running XOR 0 → DATA.
- DATA: accept bytes, shift into 32-bit assembly register, XOR into checksum. On the 4th byte of word k: write word k at address k; if k = N-1 check bits[31:26] of that word; ≠ 0 (no halt opcode) → ERR, else → CSUM. Otherwise k+1, stay.
- CSUM: accept one byte; equal to running XOR → RUN, else → ERR.
- RUN: core_reset = 0; in_ready = 0; on core_done → run_done pulse, core_reset = 1, → LEN0.
- ERR: in_ready = 0, error = 1, core_reset = 1; exit only via reset.
- in_ready combinational from state: 1 in LEN0/LEN1/DATA/CSUM, 0 in RUN/ERR.
- core_done outside RUN ignored.
- Reset values: state LEN0, prog_we 0, prog_addr 0, prog_d 0, core_reset 1, run_done 0, error 0, in_ready 1.
- Reset mid-frame: partial word discarded, no write issued; already-written RAM words not cleared. Reset in RUN: core_reset reasserts the next cycle.
- Counters: word index ADDR_W+1 bits (N = DEPTH representable); no wrap inside a valid frame.

## Timing
- Byte accepted at edge t only when in_valid && in_ready at t; in_valid with in_ready=0 is stalled, not dropped (host holds it).
- Word write: 4th byte accepted at edge t → prog_we = 1 with prog_addr/prog_d valid for the cycle after t, exactly one cycle.
- Back-to-back bytes at full rate supported; no bubbles required.
- Last write completes before core_reset falls: CSUM byte at edge t → core_reset = 0 from t+1.
- Error from LEN1, last-word, or CSUM check: error = 1 and in_ready = 0 from the cycle after the offending byte.
- core_done at edge t in RUN → run_done = 1 and core_reset = 1 for the cycle after t; LEN0 with in_ready = 1 in that same cycle.
- No state consumes more than one byte per cycle.

## Test plan
- Minimal frame: 01 00, word 0x00000000 (halt), CSUM 00 → one write addr 0 data 0; core_reset falls cycle after CSUM; core_done pulse → run_done one cycle, core_reset 1, in_ready 1.
- Three-word frame, random in_valid gaps: words 0x0400_1234, 0x0800_0055, 0x0000_0000, CSUM = XOR of the 12 bytes → writes at addr 0,1,2 with exact data; no write during gaps.
- Bad checksum (correct ^ 0x01) → error = 1, in_ready = 0, core_reset stays 1; core_done pulses ignored; reset clears error.
- Length 0 and length DEPTH+1 → ERR after LEN_HI, no prog_we; length DEPTH with halt last → DEPTH writes, last addr DEPTH-1.
- Last word 0x0400_0000 (non-halt opcode) → written, then ERR, no CSUM byte accepted.
- Reset asserted after 2 bytes of word 1 → no write for word 1; new frame then loads from addr 0 normally.
